// File: rtl/adder_serial_io.sv
// adder_serial_io
// Serial operand-load / result-unload stage around a combinational adder.
// Operands A and B arrive LSB beat first on a narrow valid/ready bus. They are
// held in full-width registers that drive the adder directly. The adder result
// is captured for one cycle and then streamed back out, LSB beat first.

module adder_serial_io #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BUS_WIDTH-1:0]  in_data,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BUS_WIDTH-1:0]  out_data,
    output logic                  out_cout,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic                  Cin,
    input  logic [DATA_WIDTH-1:0] S,
    input  logic                  Cout
);

    localparam int BEATS = DATA_WIDTH / BUS_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [DATA_WIDTH-1:0]   a_r;
    logic [DATA_WIDTH-1:0]   b_r;
    logic                    cin_r;
    logic [DATA_WIDTH-1:0]   result_r;
    logic                    cout_r;

    logic                    in_ready_s;
    logic                    out_valid_s;
    logic                    accept_s;
    logic                    send_s;
    logic                    last_beat_s;
    logic [BUS_WIDTH-1:0]    out_data_s;
    logic                    out_cout_s;

    // Select beat idx (BUS_WIDTH bits) out of a full-width word.
    function automatic logic [BUS_WIDTH-1:0] beat_of(
        input logic [DATA_WIDTH-1:0] word,
        input logic [CNT_W-1:0]      idx
    );
        logic [BUS_WIDTH-1:0] sel;
        sel = {BUS_WIDTH{1'b0}};
        for (int i = 0; i < BEATS; i++) begin
            if (idx == CNT_W'(i)) begin
                sel = word[i*BUS_WIDTH +: BUS_WIDTH];
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Handshake qualifiers decoded from state only, so no combinational
    // path exists from in_valid or out_ready to the ready/valid outputs.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            LOAD_A:  in_ready_s  = 1'b1;
            LOAD_B:  in_ready_s  = 1'b1;
            CAPTURE: in_ready_s  = 1'b0;
            SEND:    out_valid_s = 1'b1;
            default: in_ready_s  = 1'b0;
        endcase
    end

    assign accept_s    = in_valid & in_ready_s;
    assign send_s      = out_valid_s & out_ready;
    assign last_beat_s = (cnt_r == CNT_LAST);

    // Next-state logic: the final beat of each phase moves on; CAPTURE lasts one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LOAD_A: begin
                if (accept_s && last_beat_s) begin
                    state_next_s = LOAD_B;
                end else begin
                    state_next_s = LOAD_A;
                end
            end
            LOAD_B: begin
                if (accept_s && last_beat_s) begin
                    state_next_s = CAPTURE;
                end else begin
                    state_next_s = LOAD_B;
                end
            end
            CAPTURE: begin
                state_next_s = SEND;
            end
            SEND: begin
                if (send_s && last_beat_s) begin
                    state_next_s = LOAD_A;
                end else begin
                    state_next_s = SEND;
                end
            end
            default: begin
                state_next_s = LOAD_A;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD_A;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Beat counter: cleared on every state change, advanced by each accepted or sent beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_next_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s || send_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Operand registers: each accepted beat overwrites one slice; carry-in
    // is taken only with the final B beat. Not cleared between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= {DATA_WIDTH{1'b0}};
            b_r   <= {DATA_WIDTH{1'b0}};
            cin_r <= 1'b0;
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                if (accept_s && (cnt_r == CNT_W'(i))) begin
                    if (state_r == LOAD_A) begin
                        a_r[i*BUS_WIDTH +: BUS_WIDTH] <= in_data;
                    end else if (state_r == LOAD_B) begin
                        b_r[i*BUS_WIDTH +: BUS_WIDTH] <= in_data;
                    end
                end
            end
            if (accept_s && (state_r == LOAD_B) && last_beat_s) begin
                cin_r <= in_cin;
            end
        end
    end

    // Result capture: the adder output is sampled only in the CAPTURE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {DATA_WIDTH{1'b0}};
            cout_r   <= 1'b0;
        end else if (state_r == CAPTURE) begin
            result_r <= S;
            cout_r   <= Cout;
        end
    end

    // Output beat mux: zero outside SEND, otherwise the current result slice.
    always_comb begin
        out_data_s = {BUS_WIDTH{1'b0}};
        out_cout_s = 1'b0;
        if (state_r == SEND) begin
            out_data_s = beat_of(result_r, cnt_r);
            out_cout_s = cout_r;
        end else begin
            out_data_s = {BUS_WIDTH{1'b0}};
            out_cout_s = 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign out_cout  = out_cout_s;
    assign A         = a_r;
    assign B         = b_r;
    assign Cin       = cin_r;

endmodule

// File: doc/adder_serial_io.md
# adder_serial_io

Serial operand-load / result-unload stage wrapped around the combinational carry-select adder. It accepts A and B over a narrow valid/ready input bus, presents full-width registered operands to the adder, and captures the adder's sum and carry-out. It then streams the sum back out over a narrow valid/ready output bus. It sits directly upstream and downstream of the adder and is the only sequential logic on the adder datapath.

## Interface

**Parameters**
- DATA_WIDTH, 32: adder operand width. Must equal the adder's DATA_WIDTH and be an integer multiple of BUS_WIDTH.
- BUS_WIDTH, 8: width of the serial in/out buses. BEATS = DATA_WIDTH/BUS_WIDTH.

**Ports**
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: upstream beat valid.
- in_ready, output, 1: stage can accept a beat.
- in_data, input, BUS_WIDTH: operand beat, LSB beat first.
- in_cin, input, 1: carry-in, sampled on the last B beat only.
- out_valid, output, 1: result beat valid.
- out_ready, input, 1: downstream accepts the beat.
- out_data, output, BUS_WIDTH: sum beat, LSB beat first.
- out_cout, output, 1: registered adder carry-out, valid while out_valid=1.
- A, output, DATA_WIDTH: operand A register to the adder.
- B, output, DATA_WIDTH: operand B register to the adder.
- Cin, output, 1: carry-in register to the adder.
- S, input, DATA_WIDTH: adder sum.
- Cout, input, 1: adder carry-out.

## Operation

**State machine** (states LOAD_A, LOAD_B, CAPTURE, SEND; reset state LOAD_A)
- beat counter: ceil(log2(BEATS)) bits (minimum 1). Cleared to 0 on every state transition.
- accept = in_valid & in_ready; send = out_valid & out_ready.
- LOAD_A: in_ready=1. Each accept writes in_data into A slice [cnt*BUS_WIDTH +: BUS_WIDTH] and increments cnt. The accept with cnt=BEATS-1 moves to LOAD_B.
- LOAD_B: same as LOAD_A, but writes B. The accept with cnt=BEATS-1 also loads Cin<=in_cin and moves to CAPTURE.
- CAPTURE: in_ready=0, out_valid=0. Registers result<=S and cout_r<=Cout. Unconditionally moves to SEND on the next cycle.
- SEND: out_valid=1, out_data=result[cnt*BUS_WIDTH +: BUS_WIDTH], out_cout=cout_r. Each send increments cnt. The send with cnt=BEATS-1 moves to LOAD_A.

**Rules**
- in_valid=0 cycles (bubbles) do not advance cnt or alter operands.
- out_ready=0 stalls SEND. out_data and out_cout hold stable; in_ready stays 0.
- A, B and Cin are driven straight from the operand registers. The adder sees partial operands during the load states; only the CAPTURE-cycle sample is used.
- A and B are not cleared between operations. Each new operation overwrites every slice.
- in_ready and out_valid are decoded from state only; there is no combinational path from in_valid or out_ready.
- out_cout=0 and out_data=0 outside SEND.
- Arithmetic is unsigned modulo 2^DATA_WIDTH; the overflow carry is reported only on out_cout.

## Timing

- **Reset:** rst_n low asynchronously forces state=LOAD_A, cnt=0, A=B=0, Cin=0, result=0, cout_r=0. Outputs during and after reset: in_ready=1, out_valid=0, out_data=0, out_cout=0.
- **Reset mid-operation:** the partial operation is discarded. The first accept after release is A beat 0.
- **Latency:** with in_valid held high from cycle 0, the last B beat is accepted in cycle 2·BEATS−1, CAPTURE occurs in cycle 2·BEATS, and out_valid first rises in cycle 2·BEATS+1 (cycle 9 for defaults).
- **Throughput:** one operation per 3·BEATS+1 cycles with no stalls (13 for defaults).
- **Adder path:** the adder path from A/B/Cin through S/Cout to result is a single-cycle combinational path, timed within one clk period.

## Test plan

- **Reset:** assert rst_n=0 mid-SEND with out_ready=0 → out_valid=0, in_ready=1, out_data=0, out_cout=0 immediately. After release, an operation with A=5, B=3, Cin=0 returns beats 08,00,00,00 and out_cout=0.
- **Overflow:** A=0xFFFFFFFF, B=0x00000001, Cin=0, no bubbles → out_valid rises at cycle 9; beats 00,00,00,00; out_cout=1 on every beat.
- **Carry-in:** A=0x12345678, B=0x11111111, Cin=1 → beats 8A,67,45,23; out_cout=0. in_cin toggled on non-final beats has no effect.
- **Input bubbles:** same operands as the carry-in test with in_valid low for 2 cycles after every beat → identical result; out_valid rises 2·(2·BEATS−1) cycles later than the no-bubble case.
- **Output backpressure:** out_ready=0 for 3 cycles at beat 1 of result 0x2345678A → out_data holds 0x67 for all stall cycles, in_ready=0 throughout, no beat lost or duplicated. in_ready returns to 1 the cycle after the last send.
- **Reset mid-LOAD_B:** pulse rst_n after 2 B beats, then run A=0x80000000, B=0x80000000, Cin=1 → beats 01,00,00,00; out_cout=1.
